// File: rtl/sync_fifo_lvl.sv
// ============================================================================
//  Module   : sync_fifo_lvl
//  Brief    : Single-clock FWFT FIFO with fill level, almost-full/empty
//             thresholds, synchronous flush and optional sticky error flags
//             (built only when SYNC_FIFO_LVL_ERR_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_lvl #(
    parameter int FD  = 16,
    parameter int DW  = 32,
    parameter int AFT = FD - 2,
    parameter int AET = 1,
    localparam int LW = $clog2(FD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_in,
    input  logic          fifo_wr_en,
    input  logic          fifo_rd_en,
    input  logic          fifo_flush,
    input  logic          fifo_err_clr,
    output logic [DW-1:0] fifo_out,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_almost_full,
    output logic          fifo_almost_empty,
    output logic [LW-1:0] fifo_level,
    output logic          fifo_ovf,
    output logic          fifo_udf
);

    localparam int PW = $clog2(FD);

    logic [DW-1:0] r_mem [FD];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [LW-1:0] r_level;

    logic w_wr_ok;
    logic w_rd_ok;

    // Status flags decode from the level register only.
    assign fifo_level        = r_level;
    assign fifo_full         = (r_level == LW'(FD));
    assign fifo_empty        = (r_level == '0);
    assign fifo_almost_full  = (r_level >= LW'(AFT));
    assign fifo_almost_empty = (r_level <= LW'(AET));
    assign fifo_out          = r_mem[r_rp];

    // A write at full is allowed only because the paired read frees a slot.
    assign w_rd_ok = fifo_rd_en && !fifo_empty;
    assign w_wr_ok = fifo_wr_en && (!fifo_full || fifo_rd_en);

    always_ff @(posedge clk) begin
        if (!rst && !fifo_flush && w_wr_ok) begin
            r_mem[r_wp] <= fifo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= (r_wp == PW'(FD - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_rd_ok) begin
                r_rp <= (r_rp == PW'(FD - 1)) ? '0 : r_rp + PW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic r_ovf;
    logic r_udf;
    logic w_ovf_set;
    logic w_udf_set;

    // Requests swallowed by a flush are not errors.
    assign w_ovf_set = fifo_wr_en && !w_wr_ok && !fifo_flush;
    assign w_udf_set = fifo_rd_en && fifo_empty && !fifo_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (fifo_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (fifo_err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign fifo_ovf = r_ovf;
    assign fifo_udf = r_udf;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = fifo_err_clr;
    assign fifo_ovf         = 1'b0;
    assign fifo_udf         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
// ============================================================================
//  Module   : tb_sync_fifo_lvl
//  Brief    : Directed self-checking bench for sync_fifo_lvl (FD=5, DW=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

    localparam int FD  = 5;
    localparam int DW  = 8;
    localparam int AFT = 4;
    localparam int AET = 1;
    localparam int LW  = $clog2(FD + 1);
`ifdef SYNC_FIFO_LVL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_in;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          fifo_flush;
    logic          fifo_err_clr;
    logic [DW-1:0] fifo_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic [LW-1:0] fifo_level;
    logic          fifo_ovf;
    logic          fifo_udf;

    int errors = 0;
    int checks = 0;

    sync_fifo_lvl #(.FD(FD), .DW(DW), .AFT(AFT), .AET(AET)) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_in           (fifo_in),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_flush        (fifo_flush),
        .fifo_err_clr      (fifo_err_clr),
        .fifo_out          (fifo_out),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_level        (fifo_level),
        .fifo_ovf          (fifo_ovf),
        .fifo_udf          (fifo_udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fifo_wr_en   = 1'b0;
        fifo_rd_en   = 1'b0;
        fifo_flush   = 1'b0;
        fifo_err_clr = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        fifo_in = '0;
        idle();
        tick();
        tick();
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ae", 32'(fifo_almost_empty), 1);
        chk("rst_af", 32'(fifo_almost_full), 0);
        chk("rst_ovf", 32'(fifo_ovf), 0);
        chk("rst_udf", 32'(fifo_udf), 0);
        rst = 1'b0;

        // Fill with 0x01..0x05
        for (int i = 1; i <= 5; i++) begin
            fifo_in    = DW'(i);
            fifo_wr_en = 1'b1;
            tick();
            chk("fill_level", 32'(fifo_level), i);
            chk("fill_out", 32'(fifo_out), 32'h01);
            chk("fill_af", 32'(fifo_almost_full), (i >= 4) ? 1 : 0);
            chk("fill_full", 32'(fifo_full), (i == 5) ? 1 : 0);
            chk("fill_ae", 32'(fifo_almost_empty), (i <= 1) ? 1 : 0);
            chk("fill_empty", 32'(fifo_empty), 0);
        end

        // Write at full without read is refused
        fifo_in = 8'h06;
        tick();
        chk("ovf_level", 32'(fifo_level), 5);
        chk("ovf_out", 32'(fifo_out), 32'h01);
        chk("ovf_set", 32'(fifo_ovf), 32'(ERR));
        idle();
        tick();
        chk("ovf_sticky", 32'(fifo_ovf), 32'(ERR));
        fifo_err_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(fifo_ovf), 0);
        // Set beats clear in the same cycle
        fifo_wr_en = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(fifo_ovf), 32'(ERR));
        idle();
        fifo_err_clr = 1'b1;
        tick();
        chk("ovf_clr2", 32'(fifo_ovf), 0);
        idle();

        // Write+read at full
        fifo_in    = 8'h06;
        fifo_wr_en = 1'b1;
        fifo_rd_en = 1'b1;
        chk("wr_rd_full_head", 32'(fifo_out), 32'h01);
        tick();
        chk("wr_rd_full_level", 32'(fifo_level), 5);
        chk("wr_rd_full_out", 32'(fifo_out), 32'h02);
        chk("wr_rd_full_ovf", 32'(fifo_ovf), 0);
        fifo_wr_en = 1'b0;

        // Drain across pointer wrap
        for (int i = 2; i <= 6; i++) begin
            chk("drain_out", 32'(fifo_out), i);
            tick();
            chk("drain_level", 32'(fifo_level), 6 - i);
        end
        chk("drain_empty", 32'(fifo_empty), 1);
        chk("drain_udf", 32'(fifo_udf), 0);

        // Empty: write+read, read refused
        fifo_in    = 8'hAA;
        fifo_wr_en = 1'b1;
        fifo_rd_en = 1'b1;
        tick();
        chk("wr_rd_empty_level", 32'(fifo_level), 1);
        chk("wr_rd_empty_out", 32'(fifo_out), 32'hAA);
        chk("wr_rd_empty_empty", 32'(fifo_empty), 0);
        fifo_wr_en = 1'b0;
        tick();
        chk("pop_aa_level", 32'(fifo_level), 0);
        fifo_rd_en   = 1'b0;
        fifo_err_clr = 1'b1;
        tick();
        chk("udf_pre_clr", 32'(fifo_udf), 0);
        fifo_err_clr = 1'b0;

        // Lone read at empty
        fifo_rd_en = 1'b1;
        tick();
        chk("udf_set", 32'(fifo_udf), 32'(ERR));
        chk("udf_level", 32'(fifo_level), 0);
        fifo_rd_en = 1'b0;

        // Level 3 then flush with wr+rd; udf left set
        for (int i = 1; i <= 3; i++) begin
            fifo_in    = DW'(8'h11 * i);
            fifo_wr_en = 1'b1;
            tick();
        end
        chk("pre_flush_level", 32'(fifo_level), 3);
        fifo_in    = 8'h77;
        fifo_rd_en = 1'b1;
        fifo_flush = 1'b1;
        tick();
        chk("flush_level", 32'(fifo_level), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        chk("flush_udf", 32'(fifo_udf), 32'(ERR));
        chk("flush_ovf", 32'(fifo_ovf), 0);
        idle();
        fifo_in    = 8'h55;
        fifo_wr_en = 1'b1;
        tick();
        chk("post_flush_out", 32'(fifo_out), 32'h55);
        chk("post_flush_level", 32'(fifo_level), 1);

        // Fill, overflow, pop to level 4, then reset
        for (int i = 6; i <= 9; i++) begin
            fifo_in = DW'(8'h11 * i);
            tick();
        end
        chk("refill_full", 32'(fifo_full), 1);
        tick();
        chk("refill_ovf", 32'(fifo_ovf), 32'(ERR));
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b1;
        chk("refill_head", 32'(fifo_out), 32'h55);
        tick();
        fifo_rd_en = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 4);
        chk("pre_rst_out", 32'(fifo_out), 32'h66);
        chk("pre_rst_ovf", 32'(fifo_ovf), 32'(ERR));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_level", 32'(fifo_level), 0);
        chk("rst2_empty", 32'(fifo_empty), 1);
        chk("rst2_ovf", 32'(fifo_ovf), 0);
        chk("rst2_udf", 32'(fifo_udf), 0);
        chk("rst2_af", 32'(fifo_almost_full), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
